rv32_tb_mem_model: RTL and testbench
====================================

// Module: rv32_tb_mem_model
//
// PURPOSE
//   Behavioural dual-port memory model for cocotb core benches: serves the
//   core's instruction and data ports, adds a programmable read latency and
//   byte-strobed writes, and captures every store in a trace FIFO for Python
//   to drain. It also detects a store to the TOHOST address and raises a
//   sticky done flag with the exit code. It sits beside the core inside the
//   top-level test wrapper and replaces the raw wire hookup.
//
// PARAMETERS
//   ADDR_W        32            address width of both ports
//   DATA_W        32            data width; must be 32 or 64
//   DEPTH_WORDS   4096          memory depth in DATA_W words; must be a power of 2
//   RD_LATENCY    1             read latency in cycles, 0..4 (0 = combinational)
//   TOHOST_ADDR   32'h0000_1000 address whose store ends the test
//   TRACE_DEPTH   16            store-trace FIFO entries; must be a power of 2
//   INIT_FILE     ""            $readmemh image loaded at time 0 (skipped if empty)
//
// PORTS
//   clk             in   1         clock
//   rst             in   1         asynchronous reset, active-high
//   instr_req       in   1         instruction fetch request
//   instr_addr      in   ADDR_W    fetch address
//   instr_data      out  DATA_W    fetched word
//   instr_valid     out  1         instr_data valid
//   mem_re          in   1         data read request
//   mem_we          in   1         data write request
//   mem_addr        in   ADDR_W    data address
//   mem_wdata       in   DATA_W    write data
//   mem_wstrb       in   DATA_W/8  byte write enables
//   mem_data        out  DATA_W    read data
//   mem_rvalid      out  1         mem_data valid
//   trace_valid     out  1         trace FIFO not empty
//   trace_ready     in   1         bench pops the head entry
//   trace_addr      out  ADDR_W    head entry: store address
//   trace_data      out  DATA_W    head entry: store data (after strobe masking)
//   trace_strb      out  DATA_W/8  head entry: strobes
//   trace_overflow  out  1         sticky: a store was dropped because the FIFO was full
//   done            out  1         sticky: TOHOST store seen
//   done_code       out  DATA_W    wdata of the first TOHOST store
//
// BEHAVIOUR
//   - Indexing: word = addr[log2(DEPTH_WORDS)+log2(DATA_W/8)-1 : log2(DATA_W/8)].
//     Upper bits are ignored, so addresses alias modulo depth. Low byte-offset
//     bits are ignored on reads.
//   - Reads: a request at cycle t produces data and valid at cycle t+RD_LATENCY.
//     The RD_LATENCY-deep shift of {data, valid} is independent per port and
//     fully pipelined: one request per cycle per port. When RD_LATENCY=0,
//     instr_data and mem_data are combinational and valid = req.
//   - Writes: at posedge with mem_we=1, each byte i is written where
//     mem_wstrb[i]=1. mem_wstrb=0 is a legal no-op write that is still traced.
//   - Read/write collision (either port, same word, same cycle): the read
//     returns the pre-write data.
//   - mem_we and mem_re both set: the write happens and the read returns the
//     old data.
//   - Trace FIFO: every mem_we pushes {addr, wdata & strobe mask, strb}.
//     * Pop occurs when trace_valid & trace_ready.
//     * If the FIFO is full and a push arrives without a same-cycle pop, the
//       entry is dropped and trace_overflow is set.
//     * If the FIFO is full with a simultaneous push and pop, both succeed.
//     * If the FIFO is empty, no push bypass occurs: trace_valid rises the
//       cycle after the push.
//   - TOHOST: a store with word address equal to TOHOST_ADDR's word address
//     and mem_wdata != 0 sets done=1 and latches done_code on the first
//     occurrence only. Later TOHOST stores update memory and the trace but
//     leave done_code unchanged. A store of 0 does not set done.
//   - Reset (asserted at any time, even mid-transaction): immediately clears
//     all valids, the latency pipes, the FIFO pointers, trace_overflow, done
//     and done_code. In-flight reads are discarded. Memory contents are NOT
//     cleared. All data outputs read 0 during reset.
//
// STRUCTURE
//   - Package rv32_tb_pkg: trace_entry_t struct {addr, data, strb} and a
//     bytemask(strb) function.
//   - Sub-module tb_sync_fifo (WIDTH, DEPTH; push/pop/full/empty) holds the
//     store trace.
//   - Latency pipes are a generate loop inside this module.
//
// TESTING
//   1. RD_LATENCY=2: instr_req with addr 0x10 at cycle 5 -> instr_valid=1 and
//      the preloaded word at cycle 7 only. Back-to-back fetches over 0x10..0x1C
//      return 4 words on 4 consecutive cycles.
//   2. Store 0xAABBCCDD with strb 4'b0101 to 0x20 over 0x11223344 -> a later
//      read returns 0x11BB33DD. The trace head is {0x20, 0x00BB00DD, 0101}.
//   3. Same cycle: mem_we 0x55 to 0x40 and instr_req 0x40, old value 0x7 ->
//      instr_data=0x7. The next read returns 0x55.
//   4. TRACE_DEPTH=4, trace_ready=0, 5 stores -> 4 entries and
//      trace_overflow=1. With the FIFO full, push plus pop -> count stays 4,
//      overflow unchanged.
//   5. Store 1 to TOHOST, then store 3 to TOHOST -> done=1 and done_code=1.
//      A store of 0 beforehand leaves done=0.
//   6. Assert rst during a pending latency-3 read -> mem_rvalid never rises
//      for that read. Memory keeps the prior stores; done and overflow are 0.

Source files
------------

// File: rtl/rv32_tb_pkg.sv
// Shared types for the core-bench memory model: the store-trace record and
// the strobe-to-bitmask helper. Fields are sized for the widest legal
// configuration (64-bit data); narrower instances zero-extend into them.
package rv32_tb_pkg;

  localparam int TR_ADDR_W = 64;
  localparam int TR_DATA_W = 64;
  localparam int TR_STRB_W = TR_DATA_W / 8;

  // One captured store: address as issued, data already masked by strobes.
  typedef struct packed {
    logic [TR_ADDR_W-1:0] addr;
    logic [TR_DATA_W-1:0] data;
    logic [TR_STRB_W-1:0] strb;
  } trace_entry_t;

  // Expand byte strobes into a bit mask (strb[i] -> byte i all ones).
  function automatic logic [TR_DATA_W-1:0] bytemask(input logic [TR_STRB_W-1:0] strb);
    logic [TR_DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < TR_STRB_W; i++) m[i*8 +: 8] = {8{strb[i]}};
    return m;
  endfunction

endpackage

// File: rtl/tb_sync_fifo.sv
// Single-clock FIFO holding the store trace. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; otherwise it is
// ignored (the parent flags the drop). No empty-bypass: data pushed into an
// empty FIFO becomes visible the following cycle.
module tb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_do_push, w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (r_cnt == '0);
  assign full      = (r_cnt == CNT_W'(DEPTH));
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign dout      = r_mem[r_rptr];

  // Entry storage; when full with push+pop the head is read before it is overwritten.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= din;
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) r_wptr <= ptr_inc(r_wptr);
      if (w_do_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/rv32_tb_mem_model.sv
// Dual-port behavioural memory for core benches: instruction and data read
// ports with a configurable latency pipe each, byte-strobed stores, a store
// trace FIFO and TOHOST end-of-test detection. Legal ranges: DATA_W 32/64,
// DEPTH_WORDS and TRACE_DEPTH powers of two, RD_LATENCY 0..4.
import rv32_tb_pkg::*;

module rv32_tb_mem_model #(
  parameter int              ADDR_W      = 32,
  parameter int              DATA_W      = 32,
  parameter int              DEPTH_WORDS = 4096,
  parameter int              RD_LATENCY  = 1,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 'h0000_1000,
  parameter int              TRACE_DEPTH = 16,
  parameter string           INIT_FILE   = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_req,
  input  logic [ADDR_W-1:0]   instr_addr,
  output logic [DATA_W-1:0]   instr_data,
  output logic                instr_valid,
  input  logic                mem_re,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_data,
  output logic                mem_rvalid,
  output logic                trace_valid,
  input  logic                trace_ready,
  output logic [ADDR_W-1:0]   trace_addr,
  output logic [DATA_W-1:0]   trace_data,
  output logic [DATA_W/8-1:0] trace_strb,
  output logic                trace_overflow,
  output logic                done,
  output logic [DATA_W-1:0]   done_code
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH_WORDS);

  // Word index: byte offset dropped, bits above the depth ignored (aliasing).
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  logic [DATA_W-1:0]         r_mem [DEPTH_WORDS];
  logic [IDX_W-1:0]          w_widx;
  logic [1:0][DATA_W-1:0]    w_rd_data;
  logic [1:0]                w_rd_req;
  logic [1:0][DATA_W-1:0]    w_out_data;
  logic [1:0]                w_out_vld;
  trace_entry_t              w_push_ent, w_head;
  logic                      w_full, w_empty, w_pop;
  logic                      w_tohost_hit;
  logic                      r_ovf, r_done;
  logic [DATA_W-1:0]         r_code;
  logic                      w_unused;

  assign w_widx = word_idx(mem_addr);

  // Byte-strobed store. Contents survive reset by design.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int b = 0; b < STRB_W; b++)
        if (mem_wstrb[b]) r_mem[w_widx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  // Reads sample the array before this cycle's store lands, so a same-word
  // collision on either port returns the old data. Port 0 = instr, 1 = data.
  assign w_rd_data[0] = r_mem[word_idx(instr_addr)];
  assign w_rd_data[1] = r_mem[w_idx_rd()];
  assign w_rd_req     = {mem_re, instr_req};

  function automatic logic [IDX_W-1:0] w_idx_rd();
    return word_idx(mem_addr);
  endfunction

  generate
    for (genvar p = 0; p < 2; p++) begin : g_port
      if (RD_LATENCY == 0) begin : g_comb
        assign w_out_data[p] = w_rd_data[p];
        assign w_out_vld[p]  = w_rd_req[p];
      end else begin : g_pipe
        logic [RD_LATENCY-1:0][DATA_W-1:0] r_dpipe;
        logic [RD_LATENCY-1:0]             r_vpipe;

        // Latency shift of {data, valid}; reset flushes in-flight reads.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_dpipe <= '0;
            r_vpipe <= '0;
          end else begin
            r_dpipe[0] <= w_rd_data[p];
            r_vpipe[0] <= w_rd_req[p];
            for (int s = 1; s < RD_LATENCY; s++) begin
              r_dpipe[s] <= r_dpipe[s-1];
              r_vpipe[s] <= r_vpipe[s-1];
            end
          end
        end

        assign w_out_data[p] = r_dpipe[RD_LATENCY-1];
        assign w_out_vld[p]  = r_vpipe[RD_LATENCY-1];
      end
    end
  endgenerate

  // All data outputs are forced to zero while reset is held.
  assign instr_data  = rst ? '0 : w_out_data[0];
  assign instr_valid = ~rst & w_out_vld[0];
  assign mem_data    = rst ? '0 : w_out_data[1];
  assign mem_rvalid  = ~rst & w_out_vld[1];

  // Build the trace record: data is stored already masked by its strobes.
  always_comb begin
    w_push_ent      = '0;
    w_push_ent.addr = TR_ADDR_W'(mem_addr);
    w_push_ent.strb = TR_STRB_W'(mem_wstrb);
    w_push_ent.data = TR_DATA_W'(mem_wdata) & bytemask(TR_STRB_W'(mem_wstrb));
  end

  assign w_pop = ~w_empty & trace_ready;

  tb_sync_fifo #(
    .WIDTH ($bits(trace_entry_t)),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk   (clk),
    .rst   (rst),
    .push  (mem_we),
    .pop   (w_pop),
    .din   (w_push_ent),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign trace_valid = ~rst & ~w_empty;
  assign trace_addr  = rst ? '0 : w_head.addr[ADDR_W-1:0];
  assign trace_data  = rst ? '0 : w_head.data[DATA_W-1:0];
  assign trace_strb  = rst ? '0 : w_head.strb[STRB_W-1:0];

  // Sticky drop flag: a store arrived while full and nothing left that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_ovf <= 1'b0;
    else if (mem_we && w_full && !w_pop)    r_ovf <= 1'b1;
  end

  assign trace_overflow = r_ovf;

  // TOHOST matches on the full word address; a zero store is not an exit.
  assign w_tohost_hit = mem_we
                      && (mem_addr[ADDR_W-1:OFF_W] == TOHOST_ADDR[ADDR_W-1:OFF_W])
                      && (mem_wdata != '0);

  // Latch done and the exit code on the first qualifying TOHOST store only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
      r_code <= '0;
    end else if (w_tohost_hit && !r_done) begin
      r_done <= 1'b1;
      r_code <= mem_wdata;
    end
  end

  assign done      = r_done;
  assign done_code = r_code;

  // Address bits outside the word index and padding bits of the trace record.
  assign w_unused = ^{instr_addr, w_head};

endmodule

// File: tb/tb_rv32_tb_mem_model.sv
// Bench for rv32_tb_mem_model (RD_LATENCY=2, TRACE_DEPTH=4): a strobe-merge
// vector table, directed multi-cycle sequences, then a randomized run checked
// against a queue/array reference model.
module tb_rv32_tb_mem_model;

  localparam int LAT    = 2;
  localparam int TD     = 4;
  localparam logic [31:0] TOHOST = 32'h0000_1000;
  localparam int NRAND  = 700;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic [31:0] instr_data;
  logic        instr_valid;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_data;
  logic        mem_rvalid;
  logic        trace_valid, trace_ready;
  logic [31:0] trace_addr, trace_data;
  logic [3:0]  trace_strb;
  logic        trace_overflow, done;
  logic [31:0] done_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32_tb_mem_model #(
    .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(4096), .RD_LATENCY(LAT),
    .TOHOST_ADDR(TOHOST), .TRACE_DEPTH(TD), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst),
    .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_data(instr_data), .instr_valid(instr_valid),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_data(mem_data), .mem_rvalid(mem_rvalid),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_addr(trace_addr), .trace_data(trace_data), .trace_strb(trace_strb),
    .trace_overflow(trace_overflow), .done(done), .done_code(done_code)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    instr_req = 0; mem_re = 0; mem_we = 0; mem_wstrb = '0; trace_ready = 0;
  endtask

  // Inputs for a cycle are driven 1ns after posedge; outputs sampled at negedge.
  task automatic next_cyc();
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    next_cyc();
    mem_we = 1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    smp();
  endtask

  task automatic read_data(input logic [31:0] a, output logic [31:0] d);
    next_cyc();
    mem_re = 1; mem_addr = a;
    smp();
    for (int i = 0; i < LAT; i++) begin
      next_cyc();
      smp();
    end
    chk("rd_valid", mem_rvalid, 1'b1);
    d = mem_data;
  endtask

  task automatic pop_trace(input string nm, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    next_cyc();
    trace_ready = 1;
    smp();
    chk({nm, "_tvalid"}, trace_valid, 1'b1);
    chk({nm, "_taddr"},  trace_addr, a);
    chk({nm, "_tdata"},  trace_data, d);
    chk({nm, "_tstrb"},  trace_strb, s);
  endtask

  task automatic apply_reset();
    next_cyc();
    rst = 1;
    smp();
    next_cyc();
    rst = 0;
    smp();
  endtask

  // Strobe-merge vectors: old word written in full, then a strobed store.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] old;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic [31:0] exp_tr;
  } vec_t;

  // Reference model state for the randomized run.
  typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] s; } tent_t;
  logic [31:0] mdl [int];
  tent_t       tq [$];
  bit          mdl_ovf;
  bit          e_iv [NRAND];
  bit          e_mv [NRAND];
  logic [31:0] e_id [NRAND];
  logic [31:0] e_md [NRAND];

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'h0000_0FFF);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] raddr();
    return 32'h200 + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3)
         + ($urandom_range(0, 1) << 20);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vt [5];
    logic [31:0] rd;
    logic [31:0] wl [4];

    vt[0] = '{32'h20, 32'h11223344, 32'hAABBCCDD, 4'b0101, 32'h11BB33DD, 32'h00BB00DD};
    vt[1] = '{32'h24, 32'h11223344, 32'hAABBCCDD, 4'b1111, 32'hAABBCCDD, 32'hAABBCCDD};
    vt[2] = '{32'h28, 32'h11223344, 32'hAABBCCDD, 4'b0000, 32'h11223344, 32'h00000000};
    vt[3] = '{32'h2C, 32'h11223344, 32'hAABBCCDD, 4'b1010, 32'hAA22CC44, 32'hAA00CC00};
    vt[4] = '{32'h31, 32'h11223344, 32'hAABBCCDD, 4'b1000, 32'hAA223344, 32'hAA000000};

    idle_inputs();
    instr_addr = '0; mem_addr = '0; mem_wdata = '0;
    rst = 1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr_data",  instr_data, 32'h0);
    chk("rst_mem_rvalid",  mem_rvalid, 1'b0);
    chk("rst_mem_data",    mem_data, 32'h0);
    chk("rst_trace_valid", trace_valid, 1'b0);
    chk("rst_overflow",    trace_overflow, 1'b0);
    chk("rst_done",        done, 1'b0);
    chk("rst_done_code",   done_code, 32'h0);
    @(posedge clk); #1;
    rst = 0;

    // Strobed stores: merged read-back and masked trace record.
    for (int i = 0; i < 5; i++) begin
      do_store(vt[i].addr, vt[i].old, 4'hF);
      pop_trace("vec_old", vt[i].addr, vt[i].old, 4'hF);
      do_store(vt[i].addr, vt[i].wdata, vt[i].strb);
      read_data({vt[i].addr[31:2], 2'b10}, rd);
      chk("vec_merge", rd, vt[i].exp_rd);
      pop_trace("vec_new", vt[i].addr, vt[i].exp_tr, vt[i].strb);
    end

    // Fetch latency: preload, reset (memory must survive), single then burst.
    for (int i = 0; i < 4; i++) begin
      wl[i] = 32'hC0DE_0000 + 32'(i * 17);
      do_store(32'h10 + 32'(4 * i), wl[i], 4'hF);
    end
    apply_reset();
    next_cyc();
    instr_req = 1; instr_addr = 32'h10;
    smp();
    next_cyc(); smp();
    chk("fetch_t1_valid", instr_valid, 1'b0);
    next_cyc(); smp();
    chk("fetch_t2_valid", instr_valid, 1'b1);
    chk("fetch_t2_data",  instr_data, wl[0]);
    next_cyc(); smp();
    chk("fetch_t3_valid", instr_valid, 1'b0);
    for (int k = 0; k < 4 + LAT; k++) begin
      next_cyc();
      if (k < 4) begin instr_req = 1; instr_addr = 32'h10 + 32'(4 * k); end
      smp();
      if (k >= LAT) begin
        chk("burst_valid", instr_valid, 1'b1);
        chk("burst_data",  instr_data, wl[k-LAT]);
      end
    end
    next_cyc(); smp();
    chk("burst_end_valid", instr_valid, 1'b0);

    // Same-cycle store and reads of one word return the old value.
    do_store(32'h40, 32'h7, 4'hF);
    next_cyc();
    mem_we = 1; mem_addr = 32'h40; mem_wdata = 32'h55; mem_wstrb = 4'hF;
    mem_re = 1; instr_req = 1; instr_addr = 32'h40;
    smp();
    for (int i = 0; i < LAT; i++) begin next_cyc(); smp(); end
    chk("coll_instr_data", instr_data, 32'h7);
    chk("coll_mem_data",   mem_data, 32'h7);
    chk("coll_mem_rvalid", mem_rvalid, 1'b1);
    read_data(32'h40, rd);
    chk("coll_after", rd, 32'h55);

    // Trace FIFO fill, overflow, and full push+pop.
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      do_store(32'h60 + 32'(4 * i), 32'h100 + 32'(i), 4'hF);
      if (i == 4) chk("ovf_at_4", trace_overflow, 1'b0);
    end
    next_cyc(); smp();
    chk("ovf_after_5", trace_overflow, 1'b1);
    next_cyc();
    mem_we = 1; mem_addr = 32'h80; mem_wdata = 32'h200; mem_wstrb = 4'hF;
    trace_ready = 1;
    smp();
    chk("full_pp_head", trace_addr, 32'h60);
    next_cyc(); smp();
    chk("full_pp_ovf", trace_overflow, 1'b1);
    pop_trace("drain1", 32'h64, 32'h101, 4'hF);
    pop_trace("drain2", 32'h68, 32'h102, 4'hF);
    pop_trace("drain3", 32'h6C, 32'h103, 4'hF);
    pop_trace("drain4", 32'h80, 32'h200, 4'hF);
    next_cyc(); smp();
    chk("drain_empty", trace_valid, 1'b0);

    // TOHOST: zero store ignored, first nonzero latched, later ones not.
    apply_reset();
    do_store(TOHOST, 32'h0, 4'hF);
    next_cyc(); smp();
    chk("tohost0_done", done, 1'b0);
    do_store(TOHOST, 32'h1, 4'hF);
    next_cyc(); smp();
    chk("tohost1_done", done, 1'b1);
    chk("tohost1_code", done_code, 32'h1);
    do_store(TOHOST, 32'h3, 4'hF);
    next_cyc(); smp();
    chk("tohost3_done", done, 1'b1);
    chk("tohost3_code", done_code, 32'h1);
    read_data(TOHOST, rd);
    chk("tohost_mem", rd, 32'h3);

    // Reset during an in-flight read.
    do_store(32'h88, 32'h1, 4'hF);
    do_store(32'h8C, 32'h2, 4'hF);
    next_cyc(); smp();
    chk("pre_rst_ovf", trace_overflow, 1'b1);
    do_store(32'h90, 32'hFEEDFACE, 4'hF);
    next_cyc();
    mem_re = 1; mem_addr = 32'h90;
    smp();
    next_cyc();
    #2 rst = 1;
    #1;
    chk("midrst_rvalid", mem_rvalid, 1'b0);
    chk("midrst_mdata",  mem_data, 32'h0);
    chk("midrst_done",   done, 1'b0);
    chk("midrst_code",   done_code, 32'h0);
    chk("midrst_ovf",    trace_overflow, 1'b0);
    chk("midrst_tvalid", trace_valid, 1'b0);
    chk("midrst_taddr",  trace_addr, 32'h0);
    smp();
    next_cyc();
    rst = 0;
    smp();
    chk("postrst_rvalid0", mem_rvalid, 1'b0);
    next_cyc(); smp();
    chk("postrst_rvalid1", mem_rvalid, 1'b0);
    read_data(32'h90, rd);
    chk("postrst_mem", rd, 32'hFEEDFACE);

    // Randomized run against the reference model.
    apply_reset();
    mdl_ovf = 0;
    for (int t = 0; t < NRAND; t++) begin
      bit pop;
      next_cyc();
      if (t < 64) begin
        mem_we = 1; mem_addr = 32'h200 + 32'(4 * t);
        mem_wdata = $urandom; mem_wstrb = 4'hF;
      end else begin
        instr_req  = 1'($urandom_range(0, 1));
        instr_addr = raddr();
        mem_re     = 1'($urandom_range(0, 1));
        mem_we     = ($urandom_range(0, 2) == 0);
        mem_addr   = raddr();
        mem_wdata  = $urandom;
        mem_wstrb  = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) instr_addr = mem_addr;
      end
      trace_ready = ($urandom_range(0, 2) == 0);
      e_iv[t] = instr_req;
      e_mv[t] = mem_re;
      e_id[t] = instr_req ? mdl[widx(instr_addr)] : 32'h0;
      e_md[t] = mem_re ? mdl[widx(mem_addr)] : 32'h0;
      smp();

      if (t >= LAT) begin
        chk("rnd_ivalid", instr_valid, e_iv[t-LAT]);
        chk("rnd_mvalid", mem_rvalid, e_mv[t-LAT]);
        if (e_iv[t-LAT]) chk("rnd_idata", instr_data, e_id[t-LAT]);
        if (e_mv[t-LAT]) chk("rnd_mdata", mem_data, e_md[t-LAT]);
      end else begin
        chk("rnd_ivalid0", instr_valid, 1'b0);
        chk("rnd_mvalid0", mem_rvalid, 1'b0);
      end
      chk("rnd_tvalid", trace_valid, tq.size() != 0);
      if (tq.size() != 0) begin
        chk("rnd_taddr", trace_addr, tq[0].a);
        chk("rnd_tdata", trace_data, tq[0].d);
        chk("rnd_tstrb", trace_strb, tq[0].s);
      end
      chk("rnd_ovf", trace_overflow, mdl_ovf);

      pop = (tq.size() != 0) && trace_ready;
      if (pop) void'(tq.pop_front());
      if (mem_we) begin
        tent_t e;
        e.a = mem_addr;
        e.d = merge(32'h0, mem_wdata, mem_wstrb);
        e.s = mem_wstrb;
        if (tq.size() < TD) tq.push_back(e);
        else mdl_ovf = 1;
        mdl[widx(mem_addr)] = merge(mdl[widx(mem_addr)], mem_wdata, mem_wstrb);
      end
    end
    chk("rnd_done", done, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
